counter_ctrl: RTL

Run-controller for an 8-bit up-counter datapath: accepts a start request, counts 0..limit in one-shot or wrap mode, counts completed passes, and reports busy/done/wrap status. Sits between a host sequencer or register block and the counter, and is the only agent that clears, advances, holds or stops the counter.

---
 rtl/counter_pkg.sv | 18 +
 rtl/counter_ctrl_prescaler.sv | 37 +++
 rtl/counter_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter run-controller: FSM state encoding,
// default datapath widths and the run-mode encoding of cfg_mode.
package counter_pkg;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_PASS_W = 4;
  localparam int unsigned PRESCALE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_WRAP    = 1'b1;

endpackage

// File: rtl/counter_ctrl_prescaler.sv
// Tick divider for counter_ctrl: a 4-bit down-counter that emits one tick
// every (divider+1) enabled cycles. The divider is captured on load_i,
// clear_i restarts the current period, hold_i freezes the count.
module counter_ctrl_prescaler
  import counter_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_i,
  input  logic                  clear_i,
  input  logic                  run_i,
  input  logic                  hold_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] div_q;
  logic [PRESCALE_W-1:0] cnt_q;

  // Divider shadow and period down-counter; reload on terminal count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      div_q <= prescale_i;
      cnt_q <= prescale_i;
    end else if (clear_i) begin
      cnt_q <= div_q;
    end else if (run_i && !hold_i) begin
      cnt_q <= (cnt_q == '0) ? div_q : cnt_q - 1'b1;
    end
  end

  assign tick_o = run_i && !hold_i && (cnt_q == '0);

endmodule

// File: rtl/counter_ctrl.sv
// Run-controller for an up-counter datapath: one-shot or wrap counting to a
// latched limit, pass counting, busy/done/wrap status. All outputs are
// registered. Optional tick prescaler built when COUNTER_CTRL_PRESCALE_EN
// is defined.
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned PASS_W = DEF_PASS_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  hold_i,
  input  logic [WIDTH-1:0]      cfg_limit,
  input  logic                  cfg_mode,
  input  logic [PASS_W-1:0]     cfg_passes,
`ifdef COUNTER_CTRL_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] cfg_prescale,
`endif
  output logic [WIDTH-1:0]      count_o,
  output logic [PASS_W-1:0]     pass_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  wrap_o
);

  state_e              state_q;
  logic [WIDTH-1:0]    count_q;
  logic [PASS_W-1:0]   pass_q;
  logic                busy_q;
  logic                done_q;
  logic                wrap_q;
  logic [WIDTH-1:0]    limit_q;
  logic                mode_q;
  logic [PASS_W-1:0]   passes_q;
  logic [PASS_W-1:0]   pass_d;
  logic                tick;

  assign pass_d = pass_q + 1'b1;

`ifdef COUNTER_CTRL_PRESCALE_EN
  counter_ctrl_prescaler u_prescaler (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     ((state_q == IDLE) && start_i),
    .clear_i    ((state_q == RUN) && stop_i),
    .run_i      (state_q == RUN),
    .hold_i     (hold_i),
    .prescale_i (cfg_prescale),
    .tick_o     (tick)
  );
`else
  assign tick = 1'b1;
`endif

  // Control FSM with registered status outputs; done/wrap default low so
  // they can only ever pulse for a single cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      pass_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
      limit_q  <= '0;
      mode_q   <= MODE_ONESHOT;
      passes_q <= '0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            limit_q  <= cfg_limit;
            mode_q   <= cfg_mode;
            passes_q <= cfg_passes;
            count_q  <= '0;
            pass_q   <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (stop_i) begin
            count_q <= '0;
            pass_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (!hold_i && tick) begin
            if (count_q != limit_q) begin
              count_q <= count_q + 1'b1;
            end else if (mode_q == MODE_ONESHOT) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              count_q <= '0;
              wrap_q  <= 1'b1;
              pass_q  <= pass_d;
              if ((passes_q != '0) && (pass_d == passes_q)) begin
                done_q  <= 1'b1;
                state_q <= DONE;
              end
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign count_o = count_q;
  assign pass_o  = pass_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign wrap_o  = wrap_q;

endmodule
